// File: rtl/bp_be_prefetch_issuer.sv
// Stride prefetch issuer: turns a confirmed striding load into up to degree_p
// line-aligned prefetches, filtered against recent lines and bounded to the base page.
module bp_be_prefetch_issuer #(
  parameter int vaddr_width_p        = 39,
  parameter int stride_width_p       = 8,
  parameter int degree_p             = 4,
  parameter int filter_els_p         = 4,
  parameter int block_offset_width_p = 6,
  parameter int page_offset_width_p  = 12
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      confirm_v_i,
  input  logic [vaddr_width_p-1:0]  addr_i,
  input  logic [stride_width_p-1:0] stride_i,
  output logic                      trigger_ready_o,
  output logic                      pf_v_o,
  output logic [vaddr_width_p-1:0]  pf_addr_o,
  input  logic                      pf_ready_i,
  output logic [15:0]               issued_count_o,
  output logic [15:0]               dropped_count_o
);

  localparam int VA = vaddr_width_p;
  localparam int BO = block_offset_width_p;
  localparam int PO = page_offset_width_p;
  localparam int LW = VA - BO;
  localparam int KW = $clog2(degree_p + 1);
  localparam int PW = (filter_els_p > 1) ? $clog2(filter_els_p) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE} state_e;

  state_e            r_state, w_state_nxt;
  logic [LW-1:0]     r_base_line;
  logic [VA-1:0]     r_stride;
  logic [VA-1:0]     r_cur;
  logic [KW-1:0]     r_k;
  logic [LW-1:0]     r_pf_line;
  logic [LW-1:0]     r_filt [filter_els_p];
  logic [filter_els_p-1:0] r_filt_v;
  logic [PW-1:0]     r_ptr;
  logic [15:0]       r_issued;
  logic [15:0]       r_dropped;

  logic [VA-1:0]     w_cur_nxt;
  logic [KW-1:0]     w_k_nxt;
  logic              w_last;
  logic              w_page_cross;
  logic              w_filt_hit;
  logic              w_skip;
  logic              w_accept;
  logic              w_handshake;

  assign w_accept    = (r_state == S_IDLE) && confirm_v_i && (stride_i != '0);
  assign w_handshake = (r_state == S_ISSUE) && pf_ready_i;
  assign w_cur_nxt   = r_cur + r_stride;
  assign w_k_nxt     = r_k + KW'(1);
  assign w_last      = (w_k_nxt == KW'(degree_p));
  // Page comparison uses the full base page since r_base_line keeps all bits above the line offset.
  assign w_page_cross = (w_cur_nxt[VA-1:PO] != r_base_line[LW-1:PO-BO]);

  always_comb begin
    w_filt_hit = 1'b0;
    for (int unsigned i = 0; i < filter_els_p; i++) begin
      if (r_filt_v[i] && (r_filt[i] == w_cur_nxt[VA-1:BO])) w_filt_hit = 1'b1;
    end
  end

  assign w_skip = (w_cur_nxt[VA-1:BO] == r_base_line) || w_filt_hit;

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_CALC;
      S_CALC: begin
        if (w_page_cross)  w_state_nxt = S_IDLE;
        else if (w_skip)   w_state_nxt = w_last ? S_IDLE : S_CALC;
        else               w_state_nxt = S_ISSUE;
      end
      S_ISSUE: if (pf_ready_i) w_state_nxt = (r_k == KW'(degree_p)) ? S_IDLE : S_CALC;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    trigger_ready_o = (r_state == S_IDLE);
    pf_v_o          = (r_state == S_ISSUE);
    pf_addr_o       = {r_pf_line, {BO{1'b0}}};
    issued_count_o  = r_issued;
    dropped_count_o = r_dropped;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_base_line <= '0;
      r_stride    <= '0;
      r_cur       <= '0;
      r_k         <= '0;
      r_pf_line   <= '0;
      r_filt_v    <= '0;
      r_ptr       <= '0;
      r_issued    <= '0;
      r_dropped   <= '0;
      for (int unsigned i = 0; i < filter_els_p; i++) r_filt[i] <= '0;
    end else begin
      if (w_accept) begin
        r_base_line <= addr_i[VA-1:BO];
        r_stride    <= {{(VA-stride_width_p){stride_i[stride_width_p-1]}}, stride_i};
        r_cur       <= addr_i;
        r_k         <= '0;
      end
      if (r_state == S_CALC) begin
        r_cur <= w_cur_nxt;
        r_k   <= w_k_nxt;
        if (!w_page_cross && !w_skip) r_pf_line <= w_cur_nxt[VA-1:BO];
      end
      if (w_handshake) begin
        r_filt[r_ptr]   <= r_pf_line;
        r_filt_v[r_ptr] <= 1'b1;
        r_ptr           <= (r_ptr == PW'(filter_els_p - 1)) ? '0 : r_ptr + PW'(1);
        if (r_issued != '1) r_issued <= r_issued + 16'd1;
      end
      if (confirm_v_i && (r_state != S_IDLE) && (r_dropped != '1))
        r_dropped <= r_dropped + 16'd1;
    end
  end

endmodule

// File: tb/tb_bp_be_prefetch_issuer.sv
// Directed bench for bp_be_prefetch_issuer: one task per scenario, inline checks.
module tb_bp_be_prefetch_issuer;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        confirm_v_i = 1'b0;
  logic [38:0] addr_i = '0;
  logic [7:0]  stride_i = '0;
  logic        trigger_ready_o;
  logic        pf_v_o;
  logic [38:0] pf_addr_o;
  logic        pf_ready_i = 1'b0;
  logic [15:0] issued_count_o;
  logic [15:0] dropped_count_o;

  int n_vec = 0;
  int n_bad = 0;
  logic [38:0] cap_q [$];

  bp_be_prefetch_issuer #(
    .vaddr_width_p(39), .stride_width_p(8), .degree_p(4), .filter_els_p(4),
    .block_offset_width_p(6), .page_offset_width_p(12)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .confirm_v_i(confirm_v_i),
    .addr_i(addr_i), .stride_i(stride_i), .trigger_ready_o(trigger_ready_o),
    .pf_v_o(pf_v_o), .pf_addr_o(pf_addr_o), .pf_ready_i(pf_ready_i),
    .issued_count_o(issued_count_o), .dropped_count_o(dropped_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change 1 time unit after posedge, so a negedge sample predicts the next handshake.
  always @(negedge clk_i) begin
    if (reset_n_i && pf_v_o && pf_ready_i) cap_q.push_back(pf_addr_o);
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic trigger(input logic [38:0] a, input logic [7:0] s);
    tick();
    confirm_v_i = 1'b1;
    addr_i      = a;
    stride_i    = s;
    tick();
    confirm_v_i = 1'b0;
    addr_i      = 39'h7F_FFFF_FFC0;
    stride_i    = 8'h55;
  endtask

  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    while (!trigger_ready_o && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  task automatic do_reset;
    reset_n_i = 1'b0;
    tick();
    tick();
    reset_n_i = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    reset_n_i = 1'b0;
    tick();
    n_vec++;
    if ({trigger_ready_o, pf_v_o, pf_addr_o, issued_count_o, dropped_count_o} !== {1'b1, 1'b0, 39'h0, 16'h0, 16'h0}) begin
      n_bad++;
      $display("FAIL reset_state: rdy=%b v=%b addr=%h iss=%h drp=%h, required rdy=1 v=0 addr=0 cnt=0",
               trigger_ready_o, pf_v_o, pf_addr_o, issued_count_o, dropped_count_o);
    end
    reset_n_i = 1'b1;
    tick();
  endtask

  task automatic test_forward_stride;
    logic [38:0] exp_a [4] = '{39'h1040, 39'h1080, 39'h10C0, 39'h1100};
    int cyc;
    cap_q.delete();
    pf_ready_i = 1'b1;
    trigger(39'h1000, 8'd64);
    n_vec++;
    if (pf_v_o !== 1'b0 || trigger_ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL fwd_calc_cycle: v=%b rdy=%b, required v=0 rdy=0", pf_v_o, trigger_ready_o);
    end
    tick();
    n_vec++;
    if (pf_v_o !== 1'b1 || pf_addr_o !== 39'h1040) begin
      n_bad++;
      $display("FAIL fwd_latency: v=%b addr=%h, required v=1 addr=1040", pf_v_o, pf_addr_o);
    end
    wait_idle(40, cyc);
    n_vec++;
    if (cyc !== 7) begin
      n_bad++;
      $display("FAIL fwd_cycles_to_idle: got %0d, required 7", cyc);
    end
    n_vec++;
    if (cap_q.size() !== 4) begin
      n_bad++;
      $display("FAIL fwd_issue_count: got %0d, required 4", cap_q.size());
    end
    for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
      n_vec++;
      if (cap_q[i] !== exp_a[i]) begin
        n_bad++;
        $display("FAIL fwd_addr[%0d]: got %h, required %h", i, cap_q[i], exp_a[i]);
      end
    end
    n_vec++;
    if (issued_count_o !== 16'd4) begin
      n_bad++;
      $display("FAIL fwd_issued_cnt: got %0d, required 4", issued_count_o);
    end
  endtask

  task automatic test_same_line;
    int cyc;
    cap_q.delete();
    trigger(39'h1000, 8'd8);
    wait_idle(40, cyc);
    n_vec++;
    if (cyc !== 4) begin
      n_bad++;
      $display("FAIL sameline_cycles: got %0d, required 4", cyc);
    end
    n_vec++;
    if (cap_q.size() !== 0 || issued_count_o !== 16'd4) begin
      n_bad++;
      $display("FAIL sameline_issues: got %0d new, cnt %0d, required 0 new, cnt 4", cap_q.size(), issued_count_o);
    end
    trigger(39'h4000, 8'd0);
    n_vec++;
    if (trigger_ready_o !== 1'b1 || dropped_count_o !== 16'd0) begin
      n_bad++;
      $display("FAIL zero_stride_ignored: rdy=%b drp=%0d, required rdy=1 drp=0", trigger_ready_o, dropped_count_o);
    end
  endtask

  task automatic test_page_cross;
    int cyc;
    cap_q.delete();
    trigger(39'h1F80, 8'd64);
    wait_idle(40, cyc);
    n_vec++;
    if (cyc !== 3) begin
      n_bad++;
      $display("FAIL page_cycles: got %0d, required 3", cyc);
    end
    n_vec++;
    if (cap_q.size() !== 1 || (cap_q.size() > 0 && cap_q[0] !== 39'h1FC0)) begin
      n_bad++;
      $display("FAIL page_issue: got %0d issues first %h, required 1 issue 1fc0",
               cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : 39'h0);
    end
    n_vec++;
    if (issued_count_o !== 16'd5) begin
      n_bad++;
      $display("FAIL page_issued_cnt: got %0d, required 5", issued_count_o);
    end
  endtask

  task automatic test_neg_stride_filter;
    logic [38:0] exp_a [4] = '{39'h10C0, 39'h1080, 39'h1040, 39'h1000};
    int cyc;
    do_reset();
    cap_q.delete();
    pf_ready_i = 1'b1;
    trigger(39'h1100, 8'hC0);
    wait_idle(40, cyc);
    n_vec++;
    if (cap_q.size() !== 4) begin
      n_bad++;
      $display("FAIL neg_issue_count: got %0d, required 4", cap_q.size());
    end
    for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
      n_vec++;
      if (cap_q[i] !== exp_a[i]) begin
        n_bad++;
        $display("FAIL neg_addr[%0d]: got %h, required %h", i, cap_q[i], exp_a[i]);
      end
    end
    cap_q.delete();
    trigger(39'h1100, 8'hC0);
    wait_idle(40, cyc);
    n_vec++;
    if (cap_q.size() !== 0 || cyc !== 4 || issued_count_o !== 16'd4) begin
      n_bad++;
      $display("FAIL filter_repeat: got %0d new, %0d cycles, cnt %0d, required 0 new, 4 cycles, cnt 4",
               cap_q.size(), cyc, issued_count_o);
    end
  endtask

  task automatic test_backpressure_drop;
    logic [38:0] exp_a [4] = '{39'h2040, 39'h2080, 39'h20C0, 39'h2100};
    int cyc;
    cap_q.delete();
    pf_ready_i = 1'b0;
    trigger(39'h2000, 8'd64);
    tick();
    for (int i = 0; i < 5; i++) begin
      confirm_v_i = (i == 2);
      addr_i      = 39'h5000;
      stride_i    = 8'd64;
      tick();
      n_vec++;
      if (pf_v_o !== 1'b1 || pf_addr_o !== 39'h2040) begin
        n_bad++;
        $display("FAIL hold_stable[%0d]: v=%b addr=%h, required v=1 addr=2040", i, pf_v_o, pf_addr_o);
      end
    end
    confirm_v_i = 1'b0;
    n_vec++;
    if (dropped_count_o !== 16'd1) begin
      n_bad++;
      $display("FAIL dropped_cnt: got %0d, required 1", dropped_count_o);
    end
    pf_ready_i = 1'b1;
    wait_idle(40, cyc);
    n_vec++;
    if (cap_q.size() !== 4 || issued_count_o !== 16'd8) begin
      n_bad++;
      $display("FAIL bp_issue_count: got %0d, cnt %0d, required 4, cnt 8", cap_q.size(), issued_count_o);
    end
    for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
      n_vec++;
      if (cap_q[i] !== exp_a[i]) begin
        n_bad++;
        $display("FAIL bp_addr[%0d]: got %h, required %h", i, cap_q[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_async_reset;
    int cyc;
    pf_ready_i = 1'b0;
    trigger(39'h3000, 8'd64);
    tick();
    n_vec++;
    if (pf_v_o !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_valid: got %b, required 1", pf_v_o);
    end
    #2 reset_n_i = 1'b0;
    #1;
    n_vec++;
    if ({pf_v_o, pf_addr_o, trigger_ready_o, issued_count_o, dropped_count_o} !== {1'b0, 39'h0, 1'b1, 16'h0, 16'h0}) begin
      n_bad++;
      $display("FAIL async_reset: v=%b addr=%h rdy=%b iss=%0d drp=%0d, required v=0 addr=0 rdy=1 cnt=0",
               pf_v_o, pf_addr_o, trigger_ready_o, issued_count_o, dropped_count_o);
    end
    tick();
    reset_n_i = 1'b1;
    tick();
    cap_q.delete();
    pf_ready_i = 1'b1;
    trigger(39'h2000, 8'd64);
    wait_idle(40, cyc);
    n_vec++;
    if (cap_q.size() !== 4 || (cap_q.size() > 0 && cap_q[0] !== 39'h2040) || issued_count_o !== 16'd4) begin
      n_bad++;
      $display("FAIL filter_cleared: got %0d issues first %h cnt %0d, required 4 issues first 2040 cnt 4",
               cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : 39'h0, issued_count_o);
    end
  endtask

  initial begin
    test_reset();
    test_forward_stride();
    test_same_line();
    test_page_cross();
    test_neg_stride_filter();
    test_backpressure_drop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
